// File: rtl/data_mem_pkg.sv
// Shared encodings for the MEM-stage data memory: access sizes, controller states, data width.
package data_mem_pkg;
   localparam int DATA_W = 32;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {ST_CLEAR, ST_IDLE} state_t;
endpackage

// File: rtl/data_mem_lane_align.sv
// Combinational lane steering: store byte-enables/replicated data and load shift/extension.
module data_mem_lane_align
   import data_mem_pkg::*;
(
   input  logic [1:0]        i_size,
   input  logic [1:0]        i_lane,
   input  logic              i_load_unsigned,
   input  logic [DATA_W-1:0] i_write_d,
   input  logic [DATA_W-1:0] i_rd_word,
   output logic [3:0]        o_be,
   output logic [DATA_W-1:0] o_wr_word,
   output logic [DATA_W-1:0] o_ld_data
);
   logic [DATA_W-1:0] w_shift;

   assign w_shift = i_rd_word >> {i_lane, 3'b000};

   always_comb begin
      o_be      = 4'b0000;
      o_wr_word = '0;
      o_ld_data = '0;
      case (i_size)
         SZ_BYTE: begin
            o_be      = 4'b0001 << i_lane;
            o_wr_word = {4{i_write_d[7:0]}};
            o_ld_data = i_load_unsigned ? {24'h0, w_shift[7:0]}
                                        : {{24{w_shift[7]}}, w_shift[7:0]};
         end
         SZ_HALF: begin
            o_be      = i_lane[1] ? 4'b1100 : 4'b0011;
            o_wr_word = {2{i_write_d[15:0]}};
            o_ld_data = i_load_unsigned ? {16'h0, w_shift[15:0]}
                                        : {{16{w_shift[15]}}, w_shift[15:0]};
         end
         SZ_WORD: begin
            o_be      = 4'b1111;
            o_wr_word = i_write_d;
            o_ld_data = i_rd_word;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory: sized stores, extended registered loads, alignment/range checks.
// Define DATA_MEM_CLEAR_EN to build the post-reset zeroing sweep and its index counter.
module data_mem_ctrl
   import data_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 3072,
   parameter int ADDR_W      = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              memwrite,
   input  logic              memread,
   input  logic [1:0]        size,
   input  logic              load_unsigned,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] write_d,
   output logic [DATA_W-1:0] read_d,
   output logic              read_valid,
   output logic              busy,
   output logic              misaligned,
   output logic              range_err
);
   localparam int                IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [ADDR_W-1:0] N_BYTES = ADDR_W'(4 * DEPTH_WORDS);

   logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
   state_t            r_state;
   logic [DATA_W-1:0] r_read_d;
   logic              r_read_valid, r_busy, r_misaligned, r_range_err;

   logic [IDX_W-1:0]  w_word;
   logic              w_req, w_misal, w_in_range, w_ok, w_st_we, w_ld;
   logic [3:0]        w_be;
   logic [DATA_W-1:0] w_wr_word, w_ld_data;

`ifdef DATA_MEM_CLEAR_EN
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);
   logic [IDX_W-1:0] r_idx;
   logic             w_clr_we;
   assign w_clr_we = reset & (r_state == ST_CLEAR);
`endif

   assign w_word     = addr[IDX_W+1:2];
   assign w_req      = memread | memwrite;
   assign w_in_range = addr < N_BYTES;
   assign w_ok       = (r_state == ST_IDLE) & w_req & ~w_misal & w_in_range;
   assign w_st_we    = w_ok & memwrite;
   assign w_ld       = w_ok & memread & ~memwrite;

   always_comb begin
      w_misal = 1'b0;
      case (size)
         SZ_BYTE: w_misal = 1'b0;
         SZ_HALF: w_misal = addr[0];
         SZ_WORD: w_misal = |addr[1:0];
         default: w_misal = 1'b1;
      endcase
   end

   data_mem_lane_align u_align (
      .i_size          (size),
      .i_lane          (addr[1:0]),
      .i_load_unsigned (load_unsigned),
      .i_write_d       (write_d),
      .i_rd_word       (r_mem[w_word]),
      .o_be            (w_be),
      .o_wr_word       (w_wr_word),
      .o_ld_data       (w_ld_data)
   );

   // Storage: sweep writes take the array while clearing, otherwise lane-enabled stores
   always_ff @(posedge clock) begin
`ifdef DATA_MEM_CLEAR_EN
      if (w_clr_we)
         r_mem[r_idx] <= '0;
      else
`endif
      if (w_st_we) begin
         for (int b = 0; b < 4; b++)
            if (w_be[b]) r_mem[w_word][8*b +: 8] <= w_wr_word[8*b +: 8];
      end
   end

   // Controller and registered outputs; load data lands one edge after the request
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state      <= ST_CLEAR;
         r_busy       <= 1'b1;
         r_read_d     <= '0;
         r_read_valid <= 1'b0;
         r_misaligned <= 1'b0;
         r_range_err  <= 1'b0;
`ifdef DATA_MEM_CLEAR_EN
         r_idx        <= '0;
`endif
      end else begin
         r_read_valid <= 1'b0;
         r_misaligned <= 1'b0;
         r_range_err  <= 1'b0;
         case (r_state)
            ST_CLEAR: begin
`ifdef DATA_MEM_CLEAR_EN
               if (r_idx == LAST_IDX) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
`else
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
`endif
            end
            default: begin
               if (w_req & w_misal)
                  r_misaligned <= 1'b1;
               else if (w_req & ~w_in_range)
                  r_range_err <= 1'b1;
               if (w_ld) begin
                  r_read_valid <= 1'b1;
                  r_read_d     <= w_ld_data;
               end
            end
         endcase
      end
   end

   assign read_d     = r_read_d;
   assign read_valid = r_read_valid;
   assign busy       = r_busy;
   assign misaligned = r_misaligned;
   assign range_err  = r_range_err;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a byte-addressed reference model checked every cycle.
module tb_data_mem_ctrl;
   localparam int DEPTH = 16;
`ifdef DATA_MEM_CLEAR_EN
   localparam bit CLEAR_EN = 1'b1;
`else
   localparam bit CLEAR_EN = 1'b0;
`endif
   localparam int CLEAR_CYC = CLEAR_EN ? DEPTH : 1;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        memwrite = 1'b0, memread = 1'b0, load_unsigned = 1'b0;
   logic [1:0]  size = 2'b10;
   logic [31:0] addr = '0, write_d = '0;
   logic [31:0] read_d;
   logic        read_valid, busy, misaligned, range_err;

   int n_assert = 0;
   int n_fail   = 0;

   data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
      .clock(clock), .reset(reset), .memwrite(memwrite), .memread(memread),
      .size(size), .load_unsigned(load_unsigned), .addr(addr), .write_d(write_d),
      .read_d(read_d), .read_valid(read_valid), .busy(busy),
      .misaligned(misaligned), .range_err(range_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Reference model: byte-addressed memory and the expected outputs after each edge
   logic [7:0]  m_mem [0:4*DEPTH-1];
   logic [31:0] e_rd;
   logic        e_rv, e_mis, e_rerr, e_busy;
   bit          started = 1'b0;
   int          clr_left;

   initial begin : model
      int nb;
      logic [31:0] v;
      forever begin
         @(posedge clock);
         if (!reset) begin
            started = 1'b1;
            e_rd = '0; e_rv = 0; e_mis = 0; e_rerr = 0; e_busy = 1;
            clr_left = CLEAR_CYC;
         end else if (clr_left > 0) begin
            if (CLEAR_EN)
               for (int k = 0; k < 4; k++) m_mem[4*(DEPTH-clr_left)+k] = 8'h00;
            clr_left--;
            e_busy = (clr_left != 0);
            e_rv = 0; e_mis = 0; e_rerr = 0;
         end else begin
            e_rv = 0; e_mis = 0; e_rerr = 0;
            if (memread || memwrite) begin
               nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
               if (size == 2'b11 || (addr % nb) != 0)
                  e_mis = 1;
               else if (addr >= 4*DEPTH)
                  e_rerr = 1;
               else if (memwrite) begin
                  for (int k = 0; k < nb; k++) m_mem[addr+k] = write_d[8*k +: 8];
               end else begin
                  v = '0;
                  for (int k = 0; k < nb; k++) v[8*k +: 8] = m_mem[addr+k];
                  if (nb < 4 && !load_unsigned && v[8*nb-1])
                     for (int k = nb; k < 4; k++) v[8*k +: 8] = 8'hFF;
                  e_rv = 1;
                  e_rd = v;
               end
            end
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clock);
         if (started) begin
            chk("busy", {31'b0, busy}, {31'b0, e_busy});
            chk("read_valid", {31'b0, read_valid}, {31'b0, e_rv});
            chk("misaligned", {31'b0, misaligned}, {31'b0, e_mis});
            chk("range_err", {31'b0, range_err}, {31'b0, e_rerr});
            chk("read_d", read_d, e_rd);
         end
      end
   end

   task automatic step(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] d);
      memread = rd; memwrite = wr; size = sz; load_unsigned = uns; addr = a; write_d = d;
      @(negedge clock);
      memread = 1'b0; memwrite = 1'b0;
   endtask

   task automatic ld(input logic [1:0] sz, input bit uns, input logic [31:0] a);
      step(1'b1, 1'b0, sz, uns, a, 32'h0);
   endtask

   task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      step(1'b0, 1'b1, sz, 1'b0, a, d);
   endtask

   task automatic read_all();
      for (int w = 0; w < DEPTH; w++) ld(2'b10, 1'b0, 32'(4*w));
   endtask

   // Release reset while a store is held on the inputs, and measure the busy window
   task automatic release_and_count(input string nm);
      int cnt;
      cnt = 0;
      memwrite = 1'b1; size = 2'b10; addr = 32'h0; write_d = 32'hFFFF_FFFF;
      reset = 1'b1;
      for (int i = 0; i < 100 && busy; i++) begin
         @(negedge clock);
         cnt++;
      end
      memwrite = 1'b0;
      chk(nm, 32'(cnt), 32'(CLEAR_CYC));
   endtask

   initial begin
      reset = 1'b0;
      repeat (2) @(negedge clock);
      chk("reset_busy", {31'b0, busy}, 32'h1);
      chk("reset_read_d", read_d, 32'h0);
      release_and_count("busy_len_initial");
`ifndef DATA_MEM_CLEAR_EN
      for (int w = 0; w < DEPTH; w++) st(2'b10, 32'(4*w), 32'h0);
`endif
      read_all();
      chk("last_word_zero", read_d, 32'h0);

      st(2'b10, 32'h0, 32'h1111_1111);
      ld(2'b10, 1'b0, 32'h0);
      chk("word_ld_valid", {31'b0, read_valid}, 32'h1);
      chk("word_ld_data", read_d, 32'h1111_1111);

      st(2'b10, 32'h10, 32'h1234_5678);
      st(2'b00, 32'h11, 32'h0000_00AB);
      ld(2'b00, 1'b0, 32'h11);
      chk("byte_ld_signed", read_d, 32'hFFFF_FFAB);
      ld(2'b00, 1'b1, 32'h11);
      chk("byte_ld_unsigned", read_d, 32'h0000_00AB);
      ld(2'b10, 1'b1, 32'h10);
      chk("word_after_byte", read_d, 32'h1234_AB78);

      st(2'b01, 32'h12, 32'h0000_8001);
      ld(2'b01, 1'b0, 32'h12);
      chk("half_ld_signed", read_d, 32'hFFFF_8001);
      ld(2'b01, 1'b0, 32'h13);
      chk("half_misal_pulse", {31'b0, misaligned}, 32'h1);
      chk("half_misal_no_valid", {31'b0, read_valid}, 32'h0);
      chk("half_misal_hold", read_d, 32'hFFFF_8001);
      ld(2'b01, 1'b1, 32'h12);
      chk("half_ld_unsigned", read_d, 32'h0000_8001);
      ld(2'b10, 1'b0, 32'h10);
      chk("word_after_half", read_d, 32'h8001_AB78);
      ld(2'b11, 1'b0, 32'h10);
      ld(2'b10, 1'b0, 32'h12);
      st(2'b00, 32'h13, 32'h0000_005A);
      ld(2'b00, 1'b0, 32'h13);
      chk("byte_lane3", read_d, 32'h0000_005A);

      ld(2'b10, 1'b0, 32'(4*DEPTH));
      chk("range_pulse", {31'b0, range_err}, 32'h1);
      chk("range_no_misal", {31'b0, misaligned}, 32'h0);
      st(2'b10, 32'(4*DEPTH), 32'hDEAD_BEEF);
      st(2'b00, 32'(4*DEPTH+1), 32'h0000_0077);
      st(2'b01, 32'(4*DEPTH+1), 32'h0000_0077);
      chk("misal_beats_range", {31'b0, misaligned}, 32'h1);

      step(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D);
      chk("rw_both_no_valid", {31'b0, read_valid}, 32'h0);
      ld(2'b10, 1'b0, 32'h20);
      chk("rw_both_stored", read_d, 32'hCAFE_F00D);
      ld(2'b01, 1'b0, 32'h22);
      ld(2'b00, 1'b1, 32'h23);
      read_all();

`ifdef DATA_MEM_CLEAR_EN
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) st(2'b10, 32'h0, 32'h5555_5555);
`endif
      reset = 1'b0;
      @(negedge clock);
      release_and_count("busy_len_restart");
      read_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
